alu_cmd_ctrl: RTL and testbench

- Command front-end for the UART system.
- Consumes parallel bytes from the UART receiver, assembles ALU commands, drives the ALU operand, function and enable inputs, captures the registered ALU result, and streams it byte-wise to the UART transmitter.
- Sits between UART RX and the ALU on the input side, and between the ALU and UART TX on the output side.

---
 rtl/alu_cmd_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_cmd_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_ctrl.sv
// UART command front-end: assembles ALU commands from received bytes, fires the ALU,
// and streams the captured result (or a timeout error byte) to the transmitter LSB first.
module alu_cmd_ctrl #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           OUT_WIDTH  = 8,
    parameter int unsigned           FUN_WIDTH  = 4,
    parameter int unsigned           TIMEOUT    = 15,
    parameter logic [DATA_WIDTH-1:0] ERR_CODE   = 8'hEE
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic [OUT_WIDTH-1:0]  ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  ALU_EN,
    output logic [DATA_WIDTH-1:0] TX_P_DATA,
    output logic                  TX_D_VLD,
    input  logic                  TX_READY,
    output logic                  CMD_ERR
);

    localparam int unsigned NUM_BYTES = OUT_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int unsigned NUM_SLOTS = 1 << IDX_W;
    localparam int unsigned PAD_W     = NUM_SLOTS * DATA_WIDTH;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] CMD_OPERANDS = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUN_ONLY = DATA_WIDTH'(8'hDD);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GET_A   = 3'd1;
    localparam logic [2:0] S_GET_B   = 3'd2;
    localparam logic [2:0] S_GET_FUN = 3'd3;
    localparam logic [2:0] S_EXEC    = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_SEND    = 3'd6;

    logic [2:0]            state_q,    state_d;
    logic [DATA_WIDTH-1:0] alu_a_q,    alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q,    alu_b_d;
    logic [FUN_WIDTH-1:0]  alu_fun_q,  alu_fun_d;
    logic                  alu_en_q,   alu_en_d;
    logic [DATA_WIDTH-1:0] tx_data_q,  tx_data_d;
    logic                  tx_vld_q,   tx_vld_d;
    logic                  cmd_err_q,  cmd_err_d;
    logic [OUT_WIDTH-1:0]  result_q,   result_d;
    logic [IDX_W-1:0]      idx_q,      idx_d;
    logic [IDX_W-1:0]      last_idx_q, last_idx_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;

    logic [PAD_W-1:0]      res_pad;
    logic [DATA_WIDTH-1:0] res_bytes [NUM_SLOTS];
    logic [IDX_W-1:0]      idx_nxt;
    logic                  busy;

    // Result split into byte slots; slots beyond the result width read as zero.
    assign res_pad = PAD_W'(result_q);
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign res_bytes[g] = res_pad[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign idx_nxt = idx_q + IDX_W'(1);
    assign busy    = (state_q == S_EXEC) || (state_q == S_WAIT) || (state_q == S_SEND);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_fun_q  <= '0;
            alu_en_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            cmd_err_q  <= 1'b0;
            result_q   <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_fun_q  <= alu_fun_d;
            alu_en_q   <= alu_en_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            cmd_err_q  <= cmd_err_d;
            result_q   <= result_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_fun_d  = alu_fun_q;
        alu_en_d   = 1'b0;
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        cmd_err_d  = 1'b0;
        result_d   = result_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        cnt_d      = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == CMD_OPERANDS) begin
                        state_d = S_GET_A;
                    end else if (RX_P_DATA == CMD_FUN_ONLY) begin
                        state_d = S_GET_FUN;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_GET_A: begin
                if (RX_D_VLD) begin
                    alu_a_d = RX_P_DATA;
                    state_d = S_GET_B;
                end
            end
            S_GET_B: begin
                if (RX_D_VLD) begin
                    alu_b_d = RX_P_DATA;
                    state_d = S_GET_FUN;
                end
            end
            S_GET_FUN: begin
                if (RX_D_VLD) begin
                    alu_fun_d = RX_P_DATA[FUN_WIDTH-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ALU_OUT_VLD) begin
                    result_d   = ALU_OUT;
                    last_idx_d = IDX_W'(NUM_BYTES - 1);
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_SEND;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Timeout replaces the result with a single error byte.
                    result_d   = OUT_WIDTH'(ERR_CODE);
                    last_idx_d = '0;
                    idx_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_SEND;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (!tx_vld_q) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_bytes[idx_q];
                end else if (TX_READY) begin
                    if (idx_q == last_idx_q) begin
                        tx_vld_d = 1'b0;
                        idx_d    = '0;
                        state_d  = S_IDLE;
                    end else begin
                        idx_d     = idx_nxt;
                        tx_data_d = res_bytes[idx_nxt];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Bytes arriving while a command is in flight are dropped and flagged.
        if (RX_D_VLD && busy) begin
            cmd_err_d = 1'b1;
        end
    end

    assign ALU_A     = alu_a_q;
    assign ALU_B     = alu_b_q;
    assign ALU_FUN   = alu_fun_q;
    assign ALU_EN    = alu_en_q;
    assign TX_P_DATA = tx_data_q;
    assign TX_D_VLD  = tx_vld_q;
    assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl (16-bit result): behavioural ALU, byte scoreboard,
// directed scenarios followed by randomized command traffic.
module tb_alu_cmd_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 16;
    localparam int unsigned FW = 4;
    localparam int unsigned TO = 15;
    localparam int unsigned NB = OW / DW;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] RX_P_DATA;
    logic          RX_D_VLD;
    logic [OW-1:0] ALU_OUT;
    logic          ALU_OUT_VLD;
    logic [DW-1:0] ALU_A;
    logic [DW-1:0] ALU_B;
    logic [FW-1:0] ALU_FUN;
    logic          ALU_EN;
    logic [DW-1:0] TX_P_DATA;
    logic          TX_D_VLD;
    logic          TX_READY;
    logic          CMD_ERR;

    alu_cmd_ctrl #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .FUN_WIDTH(FW), .TIMEOUT(TO), .ERR_CODE(8'hEE)
    ) u_dut (
        .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD),
        .TX_READY(TX_READY), .CMD_ERR(CMD_ERR)
    );

    always #5 CLK = ~CLK;

    int n_err = 0;
    int n_chk = 0;
    int cyc   = 0;

    // Reference state: stored operands, expected TX bytes, expected event counts.
    logic [7:0]  m_a = 8'h0, m_b = 8'h0;
    logic [7:0]  exp_q[$];
    int          exp_err = 0, exp_en = 0, exp_delta = 0;
    logic [7:0]  ea = 8'h0, eb = 8'h0;
    logic [3:0]  ef = 4'h0;
    int          alu_lat = 1;
    bit          alu_stall = 1'b0;
    int          tx_mode = 0;

    int          err_cnt = 0, en_cnt = 0, en_cyc = 0;
    bit          prev_vld = 1'b0, prev_rdy = 1'b0, prev_en = 1'b0, first_pend = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] f);
        logic [15:0] x, y;
        x = {8'h00, a};
        y = {8'h00, b};
        case (f)
            4'd0:    return x + y;
            4'd1:    return x - y;
            4'd2:    return x * y;
            4'd3:    return x & y;
            4'd4:    return x | y;
            4'd5:    return x ^ y;
            default: return 16'h0000;
        endcase
    endfunction

    // Behavioural ALU with configurable latency; a stall suppresses the valid entirely.
    int alu_cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ALU_OUT_VLD <= 1'b0;
            ALU_OUT     <= '0;
            alu_cnt     <= 0;
        end else begin
            ALU_OUT_VLD <= 1'b0;
            if (ALU_EN && !alu_stall) begin
                ALU_OUT <= alu_ref(ALU_A, ALU_B, ALU_FUN);
                if (alu_lat <= 1) ALU_OUT_VLD <= 1'b1;
                else              alu_cnt     <= alu_lat - 1;
            end else if (alu_cnt != 0) begin
                alu_cnt <= alu_cnt - 1;
                if (alu_cnt == 1) ALU_OUT_VLD <= 1'b1;
            end
        end
    end

    always @(posedge CLK) cyc++;

    initial begin
        TX_READY = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (tx_mode)
                0:       TX_READY = 1'b1;
                1:       TX_READY = 1'($urandom_range(0, 1));
                default: TX_READY = 1'b0;
            endcase
        end
    end

    // Monitor, sampled mid-cycle.
    always @(negedge CLK) begin
        if (RST) begin
            if (CMD_ERR) err_cnt++;
            if (ALU_EN) begin
                en_cnt++;
                check_eq("alu_en_single", 32'(prev_en), 32'd0);
                check_eq("alu_a", 32'(ALU_A), 32'(ea));
                check_eq("alu_b", 32'(ALU_B), 32'(eb));
                check_eq("alu_fun", 32'(ALU_FUN), 32'(ef));
                en_cyc     = cyc;
                first_pend = 1'b1;
            end
            if (TX_D_VLD && !prev_vld && first_pend) begin
                check_eq("tx_latency", 32'(cyc - en_cyc), 32'(exp_delta));
                first_pend = 1'b0;
            end
            if (prev_vld && !prev_rdy) check_eq("tx_hold", 32'(TX_D_VLD), 32'd1);
            if (TX_D_VLD) begin
                if (exp_q.size() == 0) begin
                    check_eq("tx_extra", 32'(TX_D_VLD), 32'd0);
                end else begin
                    check_eq("tx_data", 32'(TX_P_DATA), 32'(exp_q[0]));
                    if (TX_READY) void'(exp_q.pop_front());
                end
            end
            prev_vld = TX_D_VLD;
            prev_rdy = TX_READY;
            prev_en  = ALU_EN;
        end else begin
            prev_vld   = 1'b0;
            prev_rdy   = 1'b0;
            prev_en    = 1'b0;
            first_pend = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge CLK); #1;
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(posedge CLK); #1;
        RX_D_VLD  = 1'b0;
    endtask

    task automatic do_cmd(input bit with_ops, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] fun_byte, input bit inject);
        logic [15:0] res;
        if (with_ops) begin
            send_byte(8'hCC);
            send_byte(a);
            send_byte(b);
            m_a = a;
            m_b = b;
        end else begin
            send_byte(8'hDD);
        end
        ea  = m_a;
        eb  = m_b;
        ef  = fun_byte[3:0];
        res = alu_ref(m_a, m_b, fun_byte[3:0]);
        if (alu_stall) begin
            exp_q.push_back(8'hEE);
            exp_delta = TO + 2;
        end else begin
            for (int i = 0; i < NB; i++) exp_q.push_back(8'(res >> (8 * i)));
            exp_delta = alu_lat + 2;
        end
        exp_en++;
        send_byte(fun_byte);
        if (inject) begin
            repeat ($urandom_range(0, 2)) @(posedge CLK);
            send_byte(8'($urandom));
            exp_err++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (n < 400 && (exp_q.size() != 0 || TX_D_VLD)) begin
            @(negedge CLK);
            n++;
        end
        repeat (2) @(negedge CLK);
        check_eq({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        check_eq({tag, "_en_cnt"}, 32'(en_cnt), 32'(exp_en));
        check_eq({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_alu_a"}, 32'(ALU_A), 32'd0);
        check_eq({tag, "_alu_b"}, 32'(ALU_B), 32'd0);
        check_eq({tag, "_alu_fun"}, 32'(ALU_FUN), 32'd0);
        check_eq({tag, "_alu_en"}, 32'(ALU_EN), 32'd0);
        check_eq({tag, "_tx_data"}, 32'(TX_P_DATA), 32'd0);
        check_eq({tag, "_tx_vld"}, 32'(TX_D_VLD), 32'd0);
        check_eq({tag, "_cmd_err"}, 32'(CMD_ERR), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int n;
        logic [7:0] b;
        RST       = 1'b0;
        RX_P_DATA = 8'h00;
        RX_D_VLD  = 1'b0;
        #7;
        check_outputs_zero("reset");
        @(posedge CLK); #1;
        RST = 1'b1;

        // Basic ADD, then operand reuse, then multi-byte MUL.
        do_cmd(1'b1, 8'h05, 8'h03, 8'h00, 1'b0);
        wait_idle("add");
        do_cmd(1'b0, 8'h00, 8'h00, 8'h01, 1'b0);
        wait_idle("sub_reuse");
        do_cmd(1'b1, 8'h10, 8'h20, 8'h02, 1'b0);
        wait_idle("mul");

        // Unknown command byte: one error pulse, nothing else.
        send_byte(8'h55);
        exp_err++;
        wait_idle("unknown");

        // Extra byte while the command is in flight; upper FUN bits ignored.
        alu_lat = 3;
        do_cmd(1'b1, 8'hF0, 8'h0F, 8'hA5, 1'b1);
        wait_idle("inject");
        alu_lat = 1;

        // ALU never answers: single error byte after the timeout.
        alu_stall = 1'b1;
        do_cmd(1'b1, 8'h09, 8'h04, 8'h00, 1'b0);
        wait_idle("timeout");
        alu_stall = 1'b0;

        // Transmitter back-pressure for 10 cycles.
        tx_mode = 2;
        do_cmd(1'b1, 8'h21, 8'h43, 8'h04, 1'b0);
        n = 0;
        while (n < 50 && !TX_D_VLD) begin
            @(negedge CLK);
            n++;
        end
        hold = 0;
        repeat (10) begin
            hold += int'(TX_D_VLD);
            @(negedge CLK);
        end
        check_eq("stall_hold_cycles", 32'(hold), 32'd10);
        tx_mode = 0;
        wait_idle("stall");

        // Reset while collecting operand B, then fresh commands.
        send_byte(8'hCC);
        send_byte(8'h77);
        RST = 1'b0;
        #1;
        check_outputs_zero("mid_reset");
        m_a = 8'h00;
        m_b = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        do_cmd(1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_idle("after_reset_dd");
        do_cmd(1'b1, 8'h12, 8'h34, 8'h00, 1'b0);
        wait_idle("after_reset_cc");

        // Randomized traffic.
        tx_mode = 1;
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind      = int'($urandom_range(0, 9));
            alu_lat   = int'($urandom_range(1, 4));
            alu_stall = ($urandom_range(0, 9) == 0);
            if (kind == 0) begin
                b = 8'($urandom);
                if (b == 8'hCC || b == 8'hDD) b = 8'h55;
                send_byte(b);
                exp_err++;
            end else begin
                do_cmd(kind > 2, 8'($urandom), 8'($urandom),
                       {4'($urandom), 4'($urandom_range(0, 6))},
                       $urandom_range(0, 3) == 0);
            end
            wait_idle("rand");
            alu_stall = 1'b0;
        end
        tx_mode = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
